// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// instruction word width and the halt opcode.
package fetch_pkg;

    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection: sequential increment, absolute branch,
// or relative branch from the address of the last issued instruction.
module instr_fetch_next_pc #(
    parameter int D = 12
) (
    input  logic              [D-1:0] prog_ctr,
    input  logic              [D-1:0] instr_pc,
    input  logic                      branch_en,
    input  logic                      branch_rel,
    input  logic              [D-1:0] branch_target,
    input  logic signed       [7:0]   branch_offset,
    output logic              [D-1:0] next_pc
);

    logic signed [D-1:0] offset_ext;

    always_comb begin
        // Signed size cast sign-extends the 8-bit offset to the PC width.
        offset_ext = D'(branch_offset);
        if (!branch_en) begin
            next_pc = prog_ctr + D'(1);
        end else if (branch_rel) begin
            next_pc = instr_pc + $unsigned(offset_ext);
        end else begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives an external combinational ROM address and
// registers the returned word, with stall, branch redirect and halt detection.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               branch_rel,
    input  logic [D-1:0]       branch_target,
    input  logic signed [7:0]  branch_offset,
    output logic [D-1:0]       prog_ctr,
    input  logic [INSTR_W-1:0] mach_code,
    output logic [INSTR_W-1:0] instr,
    output logic [D-1:0]       instr_pc,
    output logic               instr_valid,
    output logic               done
);

    fetch_state_e       state, state_d;
    logic [D-1:0]       prog_ctr_d;
    logic [INSTR_W-1:0] instr_d;
    logic [D-1:0]       instr_pc_d;
    logic               instr_valid_d;
    logic               done_d;
    logic [D-1:0]       next_pc;

    instr_fetch_next_pc #(
        .D(D)
    ) u_next_pc (
        .prog_ctr      (prog_ctr),
        .instr_pc      (instr_pc),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prog_ctr    <= START_ADDR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            prog_ctr    <= prog_ctr_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= instr_valid_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d       = state;
        prog_ctr_d    = prog_ctr;
        instr_d       = instr;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        done_d        = done;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_d       = RUN;
                    prog_ctr_d    = START_ADDR;
                    instr_valid_d = 1'b0;
                    done_d        = 1'b0;
                end
            end
            RUN: begin
                // Branch wins over stall; the word fetched on the wrong path is dropped.
                if (branch_en) begin
                    prog_ctr_d    = next_pc;
                    instr_valid_d = 1'b0;
                end else if (!stall) begin
                    if (mach_code == HALT_CODE) begin
                        state_d       = HALT;
                        done_d        = 1'b1;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = mach_code;
                        instr_pc_d    = prog_ctr;
                        instr_valid_d = 1'b1;
                        prog_ctr_d    = next_pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter D, default 12, meaning program-counter / instruction-address width.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning the address loaded into prog_ctr on start.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning begin fetching from START_ADDR (level, sampled per cycle).
REQ-006 SHALL have port stall  input  1  meaning hold PC and instruction register this cycle.
REQ-007 SHALL have port branch_en  input  1  meaning redirect the PC this cycle.
REQ-008 SHALL have port branch_rel  input  1  meaning 1 = relative branch, 0 = absolute branch.
REQ-009 SHALL have port branch_target  input  D  meaning absolute branch address.
REQ-010 SHALL have port branch_offset  input  8  meaning signed relative offset, applied to instr_pc.
REQ-011 SHALL have port prog_ctr  output  D  meaning the address driven to the combinational instruction ROM.
REQ-012 SHALL have port mach_code  input  9  meaning the ROM word at prog_ctr, valid in the same cycle.
REQ-013 SHALL have port instr  output  9  meaning the registered instruction.
REQ-014 SHALL have port instr_pc  output  D  meaning the address instr was fetched from.
REQ-015 SHALL have port instr_valid  output  1  meaning instr/instr_pc hold an issued instruction.
REQ-016 SHALL have port done  output  1  meaning the program has halted.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT.
REQ-018 IDLE/HALT with start=1 SHALL go to RUN next cycle, with prog_ctr<=START_ADDR, instr_valid<=0, done<=0.
REQ-019 start SHALL be ignored in RUN.
REQ-020 RUN, no branch, no stall, mach_code!=HALT_CODE: instr<=mach_code, instr_pc<=prog_ctr, instr_valid<=1, prog_ctr<=prog_ctr+1 (modulo 2^D, 2^D-1 wraps to 0 silently).
REQ-021 RUN, stall=1, branch_en=0: prog_ctr, instr, instr_pc, instr_valid all held.
REQ-022 RUN, branch_en=1: prog_ctr<=branch_target (abs) or instr_pc+sign-extended branch_offset modulo 2^D (rel); instr_valid<=0 (wrong-path word flushed); branch SHALL override stall.
REQ-023 RUN, no branch, no stall, mach_code==HALT_CODE (9'h1FF): state<=HALT, done<=1, instr_valid<=0, prog_ctr held at the halt address; halt word never issued.
REQ-024 branch_en and stall SHALL be ignored in IDLE and HALT.
REQ-025 done SHALL stay 1 in HALT until start; it SHALL be 0 in IDLE and RUN.
REQ-026 Latency: word at address A appears on instr one clock after prog_ctr==A with no stall.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, prog_ctr=START_ADDR, instr=0, instr_pc=0, instr_valid=0, done=0, including mid-RUN or mid-stall.
REQ-028 First edge after rst_n deasserts SHALL be evaluated as normal IDLE behaviour.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state enum, INSTR_W=9, HALT_CODE=9'h1FF.
REQ-030 Next-PC selection (increment/absolute/relative) SHALL be a combinational sub-module instr_fetch_next_pc.
REQ-031 The ROM SHALL remain external; this block only drives prog_ctr and consumes mach_code.

Verification
REQ-032 ROM 0..3 = 9'h001,002,003,1FF; start pulse -> instr 001,002,003 with instr_pc 0,1,2 on consecutive cycles, then done=1, prog_ctr=3, instr_valid=0.
REQ-033 stall=1 for 3 cycles while prog_ctr=5 -> prog_ctr, instr, instr_pc unchanged for exactly 3 cycles, fetch resumes at 5.
REQ-034 branch_en=1, branch_rel=1, instr_pc=10, offset=-4 -> prog_ctr=6 next cycle, instr_valid=0 that cycle; abs target 12'h800 -> prog_ctr=12'h800; branch with stall=1 still redirects.
REQ-035 prog_ctr=12'hFFF, non-halt word, no stall -> prog_ctr=0, instr_pc=12'hFFF.
REQ-036 rst_n pulled low mid-RUN between clock edges -> all outputs at reset values without a clock edge; start after release restarts at START_ADDR.
REQ-037 start while in HALT -> done=0 and fetch from START_ADDR; start while RUN -> no effect.
